and_or: RTL and testbench
=========================

AND_OR -- requirements
Module: and_or

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of every data port; legal range 1..64.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low; sampled on rising clock edge only.
REQ-004 a  input  WIDTH  gate operand A.
REQ-005 b  input  WIDTH  gate operand B.
REQ-006 and_y  output  WIDTH  combinational bitwise a AND b.
REQ-007 or_y  output  WIDTH  combinational bitwise a OR b.
REQ-008 and_r  output  WIDTH  registered a AND b.
REQ-009 or_r  output  WIDTH  registered a OR b.
REQ-010 en  input  1  state-update enable for the JK register.
REQ-011 j  input  WIDTH  per-bit JK set input.
REQ-012 k  input  WIDTH  per-bit JK reset input.
REQ-013 q  output  WIDTH  JK register state.
REQ-014 qp  output  WIDTH  complement of q.

Function
REQ-015 and_y SHALL equal a & b per bit, zero latency, no dependence on clock or reset_n.
REQ-016 or_y SHALL equal a | b per bit, zero latency, no dependence on clock or reset_n.
REQ-017 and_r/or_r SHALL load and_y/or_y at every rising edge with reset_n=1; latency exactly 1 cycle; not gated by en.
REQ-018 JK next state SHALL be built from the block's own AND/OR terms: d = (j & qp) | (~k & q), per bit, bits independent.
REQ-019 On a rising edge with reset_n=1 and en=1, q SHALL load d.
REQ-020 Per-bit truth: j=0,k=0 hold; j=1,k=0 set to 1; j=0,k=1 clear to 0; j=1,k=1 toggle.
REQ-021 On a rising edge with reset_n=1 and en=0, q SHALL hold regardless of j, k.
REQ-022 qp SHALL equal ~q at all times, including during and directly after reset; no independent storage and no skew cycle.
REQ-023 j, k, a, b changes between edges SHALL have no effect on q, and_r or or_r; the register is edge-triggered, not level-transparent.
REQ-024 Unknown (X) inputs are not supported; any X on q after reset is a bench error.

Reset
REQ-025 reset_n=0 at a rising edge SHALL force q=0, qp=all ones, and_r=0, or_r=0 on that edge.
REQ-026 Reset SHALL take priority over en, j and k.
REQ-027 Reset asserted mid-operation SHALL discard pending JK state; no memory of prior q is kept.
REQ-028 Deassertion SHALL take effect at the first rising edge with reset_n=1; that edge performs a normal update.
REQ-029 and_y/or_y SHALL remain live during reset.
REQ-030 Before the first reset edge, q, qp, and_r and or_r are undefined; the bench SHALL apply reset first.

Verification
REQ-031 WIDTH=1; a,b sweep 00,01,10,11 -> and_y 0,0,0,1; or_y 0,1,1,1 immediately; and_r/or_r same values one edge later.
REQ-032 WIDTH=1; reset, then en=1 with per-edge (j,k) = (1,0),(0,0),(1,1),(1,1),(0,1),(0,0) -> q after each edge 1,1,0,1,0,0; qp always ~q.
REQ-033 WIDTH=4; reset, then q=4'b0000 with j=4'b1010, k=4'b0000 -> q=4'b1010; then j=k=4'b1111 -> q=4'b0101, qp=4'b1010.
REQ-034 en=0 with j=1,k=0 for 3 edges from q=0 -> q stays 0; en=1 on next edge -> q=1.
REQ-035 q=1, reset_n=0 with j=1,k=0,en=1 -> q=0, qp=1, and_r=0, or_r=0 at that edge; reset_n=1 next edge -> q=1.
REQ-036 Toggle j,k between edges with no clock edge -> q unchanged.

Source files
------------

// File: rtl/and_or.sv
`default_nettype none
// ============================================================================
// Module      : and_or
// Description : Bitwise AND/OR gate pair with combinational and registered
//               outputs, plus a per-bit JK register whose next state is built
//               from the same AND/OR primitives.
//
// Ports
//   clock    in   1      sole clock, rising-edge active
//   reset_n  in   1      synchronous active-low reset
//   a, b     in   WIDTH  gate operands
//   and_y    out  WIDTH  a & b, combinational
//   or_y     out  WIDTH  a | b, combinational
//   and_r    out  WIDTH  a & b, registered (1-cycle latency, not gated by en)
//   or_r     out  WIDTH  a | b, registered (1-cycle latency, not gated by en)
//   en       in   1      JK register update enable
//   j, k     in   WIDTH  per-bit JK set / reset inputs
//   q        out  WIDTH  JK register state
//   qp       out  WIDTH  complement of q
//
// Revision    : 1.0  initial release
// ============================================================================
module and_or #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_y,
    output logic [WIDTH-1:0] or_y,
    output logic [WIDTH-1:0] and_r,
    output logic [WIDTH-1:0] or_r,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qp
);

    // ------------------------------------------------------------------
    // Combinational gates: live at all times, including during reset.
    // ------------------------------------------------------------------
    assign and_y = a & b;
    assign or_y  = a | b;

    // ------------------------------------------------------------------
    // Registered gate outputs: follow the gates every edge, independent
    // of en.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_and;
    logic [WIDTH-1:0] r_or;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_and <= '0;
            r_or  <= '0;
        end else begin
            r_and <= and_y;
            r_or  <= or_y;
        end
    end

    assign and_r = r_and;
    assign or_r  = r_or;

    // ------------------------------------------------------------------
    // JK register. Each bit is independent; next state is
    //   d = (j & ~q) | (~k & q)
    // which gives hold / set / clear / toggle for jk = 00 / 10 / 01 / 11.
    // qp is derived from q rather than stored, so the two can never skew.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic w_set_term;   // j AND (not q): sets or toggles a 0 to 1
        logic w_keep_term;  // (not k) AND q: keeps a 1 unless cleared

        assign w_set_term  = j[gi] & qp[gi];
        assign w_keep_term = ~k[gi] & r_q[gi];
        assign w_d[gi]     = w_set_term | w_keep_term;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_d;
        end
    end

    assign q  = r_q;
    assign qp = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_and_or.sv
`default_nettype none
// ============================================================================
// Module      : tb_and_or
// Description : Directed self-checking bench for and_or. One instance at
//               WIDTH=1 and one at WIDTH=4 share clock and reset.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_and_or;

    logic       clock;
    logic       reset_n;

    // WIDTH=1 instance signals
    logic [0:0] a1, b1, j1, k1;
    logic       en1;
    logic [0:0] and_y1, or_y1, and_r1, or_r1, q1, qp1;

    // WIDTH=4 instance signals
    logic [3:0] a4, b4, j4, k4;
    logic       en4;
    logic [3:0] and_y4, or_y4, and_r4, or_r4, q4, qp4;

    int n_checks = 0;
    int n_errors = 0;

    and_or #(.WIDTH(1)) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a1),
        .b       (b1),
        .and_y   (and_y1),
        .or_y    (or_y1),
        .and_r   (and_r1),
        .or_r    (or_r1),
        .en      (en1),
        .j       (j1),
        .k       (k1),
        .q       (q1),
        .qp      (qp1)
    );

    and_or #(.WIDTH(4)) u_dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a4),
        .b       (b4),
        .and_y   (and_y4),
        .or_y    (or_y4),
        .and_r   (and_r4),
        .or_r    (or_r4),
        .en      (en4),
        .j       (j4),
        .k       (k4),
        .q       (q4),
        .qp      (qp4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Directed vectors
    logic [1:0] ab_vec   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       and_exp  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       or_exp   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] jk_vec   [6] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00};
    logic       q_exp    [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        reset_n = 1'b0;
        a1 = '0; b1 = '0; j1 = '0; k1 = '0; en1 = 1'b0;
        a4 = '0; b4 = '0; j4 = '0; k4 = '0; en4 = 1'b0;

        // ---------------- reset state ----------------
        a1 = 1'b1; b1 = 1'b1;
        a4 = 4'b1100; b4 = 4'b1010;
        tick();
        check("rst_q1",     q1,     64'h0);
        check("rst_qp1",    qp1,    64'h1);
        check("rst_and_r1", and_r1, 64'h0);
        check("rst_or_r1",  or_r1,  64'h0);
        check("rst_q4",     q4,     64'h0);
        check("rst_qp4",    qp4,    64'hf);
        check("rst_and_y1_live", and_y1, 64'h1);
        check("rst_or_y4_live",  or_y4,  64'he);

        // ---------------- gate sweep, WIDTH=1 ----------------
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = ab_vec[i][1];
            b1 = ab_vec[i][0];
            #1;
            check($sformatf("and_y1_%0d", i), and_y1, {63'b0, and_exp[i]});
            check($sformatf("or_y1_%0d", i),  or_y1,  {63'b0, or_exp[i]});
            tick();
            check($sformatf("and_r1_%0d", i), and_r1, {63'b0, and_exp[i]});
            check($sformatf("or_r1_%0d", i),  or_r1,  {63'b0, or_exp[i]});
        end
        check("q1_held_en0", q1, 64'h0);

        // ---------------- gate check, WIDTH=4 ----------------
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check("and_y4", and_y4, 64'h8);
        check("or_y4",  or_y4,  64'he);
        tick();
        check("and_r4", and_r4, 64'h8);
        check("or_r4",  or_r4,  64'he);

        // ---------------- JK, WIDTH=4: set then toggle ----------------
        en4 = 1'b1; j4 = 4'b1010; k4 = 4'b0000;
        tick();
        check("q4_set",  q4,  64'ha);
        check("qp4_set", qp4, 64'h5);
        j4 = 4'b1111; k4 = 4'b1111;
        tick();
        check("q4_tgl",  q4,  64'h5);
        check("qp4_tgl", qp4, 64'ha);
        en4 = 1'b0;

        // ---------------- JK sequence, WIDTH=1 ----------------
        en1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            j1 = jk_vec[i][1];
            k1 = jk_vec[i][0];
            tick();
            check($sformatf("jk_q1_%0d", i),  q1,  {63'b0, q_exp[i]});
            check($sformatf("jk_qp1_%0d", i), qp1, {63'b0, ~q_exp[i]});
        end

        // ---------------- enable gating ----------------
        en1 = 1'b0; j1 = 1'b1; k1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("en0_hold_%0d", i), q1, 64'h0);
        end
        en1 = 1'b1;
        tick();
        check("en1_set", q1, 64'h1);

        // ---------------- no edge, inputs wiggle ----------------
        j1 = 1'b1; k1 = 1'b1; #1;
        j1 = 1'b0; k1 = 1'b1; #1;
        j1 = 1'b1; k1 = 1'b1; #1;
        a1 = 1'b0; b1 = 1'b0; #1;
        check("noedge_q1",     q1,     64'h1);
        check("noedge_and_r1", and_r1, 64'h1);
        check("noedge_or_r1",  or_r1,  64'h1);
        j1 = 1'b0; k1 = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        tick();
        check("hold_q1", q1, 64'h1);

        // ---------------- reset priority mid-operation ----------------
        reset_n = 1'b0; en1 = 1'b1; j1 = 1'b1; k1 = 1'b0;
        tick();
        check("midrst_q1",     q1,     64'h0);
        check("midrst_qp1",    qp1,    64'h1);
        check("midrst_and_r1", and_r1, 64'h0);
        check("midrst_or_r1",  or_r1,  64'h0);
        check("midrst_q4",     q4,     64'h0);
        reset_n = 1'b1;
        tick();
        check("postrst_q1",     q1,     64'h1);
        check("postrst_qp1",    qp1,    64'h0);
        check("postrst_and_r1", and_r1, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
